multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits; the block SHALL support power-of-two values from 4 to 32.
REQ-002 Parameter IMMW, default 5, immediate width; the block SHALL support IMMW < WIDTH.
REQ-003 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-005 START  input  1  operation request; it SHALL be accepted only on an edge where BUSY=0.
REQ-006 OP  input  4  opcode (op_mne encoding), sampled on acceptance.
REQ-007 T  input  1  toggle/mode bit, sampled on acceptance.
REQ-008 INPUTA, INPUTB  input  WIDTH  operands, sampled on acceptance.
REQ-009 IMM  input  IMMW  immediate, sampled on acceptance.
REQ-010 BUSY  output  1  high while a multi-cycle operation runs.
REQ-011 DONE  output  1  one-cycle pulse; OUT, OUT_HI, ZERO and CARRY are valid in this cycle.
REQ-012 OUT  output  WIDTH  registered result, low half.
REQ-013 OUT_HI  output  WIDTH  registered result, high half; nonzero only after kMUL.
REQ-014 ZERO  output  1  registered zero flag of the last result.
REQ-015 CARRY  output  1  persistent carry flag register.

Function
REQ-016 Acceptance in cycle c SHALL produce DONE in cycle c+L, where L is the operation latency.
REQ-017 BUSY SHALL be high in cycles c+1 .. c+L-1 and low in the DONE cycle, so back-to-back START in the DONE cycle is accepted.
REQ-018 START while BUSY=1 SHALL be ignored, with no effect on state or outputs.
REQ-019 FSM states are IDLE and RUN; IDLE->RUN on acceptance when L>1; RUN->IDLE when the cycle counter reaches L-1; L=1 ops never enter RUN.
REQ-020 kADD (L=1): {CARRY,OUT} = INPUTA + INPUTB + (T ? CARRY : 0), i.e. T selects add-with-carry.
REQ-021 kXOR (L=1): OUT = INPUTA ^ INPUTB.
REQ-022 kGST (L=1): OUT = T ? INPUTB : INPUTA.
REQ-023 kACC (L=1): OUT = IMM zero-extended to WIDTH.
REQ-024 kENQ (L=1): OUT = 1 when (INPUTA==INPUTB) XOR T, else 0.
REQ-025 kEQI (L=1): OUT = 1 when (INPUTB==zero-extended IMM) XOR T, else 0.
REQ-026 kLRS: shift INPUTA one bit per cycle; T=1 logical right, T=0 left; count n = INPUTB[clog2(WIDTH):0] saturated to WIDTH.
REQ-027 kLRS latency SHALL be L = max(n,1); n=0 returns INPUTA unchanged and leaves CARRY unchanged.
REQ-028 For n>=1, CARRY SHALL hold the last bit shifted out; n>=WIDTH SHALL give OUT=0.
REQ-029 kMUL: unsigned shift-add multiply, one partial product per cycle, L=WIDTH; {OUT_HI,OUT} = INPUTA*INPUTB; CARRY unchanged.
REQ-030 Only kADD and kLRS SHALL modify CARRY.
REQ-031 OUT_HI SHALL be cleared by every operation other than kMUL.
REQ-032 ZERO SHALL be 1 iff {OUT_HI,OUT}==0, updated together with the result.
REQ-033 Undefined opcodes SHALL give L=1, OUT=0, OUT_HI=0, ZERO=1, CARRY unchanged.
REQ-034 OUT, OUT_HI, ZERO and CARRY SHALL hold their values between DONE pulses; intermediate shift/multiply values SHALL NOT appear on OUT before DONE.

Reset
REQ-035 RESET_N low SHALL immediately force IDLE, BUSY=0, DONE=0, OUT=0, OUT_HI=0, ZERO=0, CARRY=0 and the counter to 0.
REQ-036 Reset during RUN SHALL abort the operation with no later DONE; the first START after RESET_N rises SHALL be accepted normally.

Structure
REQ-037 The definitions package SHALL hold the op_mne opcode enum (extended with kMUL) and the FSM state enum.
REQ-038 The shift-add multiplier datapath SHALL be a sub-module named shift_add_mul; the counter and FSM remain in multicycle_alu.

Verification (WIDTH=8)
REQ-039 kADD A=0xFF B=0x01 T=0 -> c+1: OUT=0x00, CARRY=1, ZERO=1, DONE=1; then kADD A=0x01 B=0x01 T=1 -> OUT=0x03, CARRY=0.
REQ-040 kLRS A=0x81 B=3 T=0 -> BUSY high c+1..c+2; c+3: DONE=1, OUT=0x08, CARRY=0; OUT stays at its previous value during c+1..c+2.
REQ-041 kLRS A=0xFF B=9 T=1 -> c+8: OUT=0x00, ZERO=1, CARRY=1.
REQ-042 kMUL A=0xFF B=0xFF with START also pulsed at c+3 -> single DONE at c+8, {OUT_HI,OUT}=0xFE01; the c+3 request is ignored.
REQ-043 kMUL started, RESET_N low at c+4 -> all outputs 0 at once, no DONE afterwards; a following kXOR A=0x0F B=0xFF -> OUT=0xF0 one cycle after acceptance.
REQ-044 Back-to-back: kLRS n=2 then kEQI accepted in its DONE cycle with B=0x05 IMM=5 T=0 -> second DONE one cycle later with OUT=0x01; an undefined OP -> OUT=0, ZERO=1.

Source files
------------

// File: rtl/multicycle_alu_pkg.sv
// multicycle_alu_pkg: opcode and FSM state definitions shared by the ALU and its bench.
package multicycle_alu_pkg;
  typedef enum logic [3:0] {
    kADD = 4'd0,
    kXOR = 4'd1,
    kGST = 4'd2,
    kACC = 4'd3,
    kENQ = 4'd4,
    kEQI = 4'd5,
    kLRS = 4'd6,
    kMUL = 4'd7
  } op_mne;
  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/multicycle_alu_mul.sv
// shift_add_mul: unsigned shift-add multiplier, one partial product per load/step/finish edge.
module shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod
);
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0] mplier;
  // prod already folds in the pending partial product so the finishing edge needs no extra step
  assign prod = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (load) begin
      acc <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand <= {{WIDTH{1'b0}}, a} << 1;
      mplier <= b >> 1;
    end else if (step) begin
      acc <= prod;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle logic ops plus multi-cycle shift and shift-add multiply.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMMW  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             t,
  input  logic [WIDTH-1:0] inputa,
  input  logic [WIDTH-1:0] inputb,
  input  logic [IMMW-1:0]  imm,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             carry
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_e state, state_nxt;
  logic [CW-1:0] cnt, len, len_q, n;
  logic [3:0] op_q;
  logic t_q, tt, sbit, accept, fin, res_c;
  logic [WIDTH-1:0] sh, src, shifted, res;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] prod;
  assign accept = start && state == IDLE;
  assign fin = state == RUN && cnt == len_q - CW'(1);
  assign n = inputb[CW-1:0] > CW'(WIDTH) ? CW'(WIDTH) : inputb[CW-1:0];
  assign len = op == kLRS ? (n == '0 ? CW'(1) : n) : op == kMUL ? CW'(WIDTH) : CW'(1);
  // one shift per edge: from the operand on acceptance, from the working register while running
  assign tt = state == IDLE ? t : t_q;
  assign src = state == IDLE ? inputa : sh;
  assign shifted = tt ? src >> 1 : src << 1;
  assign sbit = tt ? src[0] : src[WIDTH-1];
  assign sum = {1'b0, inputa} + {1'b0, inputb} + (WIDTH+1)'(t & carry);
  always_comb begin
    res = '0;
    res_c = carry;
    case (op)
      kADD: {res_c, res} = sum;
      kXOR: res = inputa ^ inputb;
      kGST: res = t ? inputb : inputa;
      kACC: res = WIDTH'(imm);
      kENQ: res = WIDTH'((inputa == inputb) ^ t);
      kEQI: res = WIDTH'((inputb == WIDTH'(imm)) ^ t);
      kLRS: {res_c, res} = n == '0 ? {carry, inputa} : {sbit, shifted};
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb state_nxt = state == IDLE ? (accept && len != CW'(1) ? RUN : IDLE) : (fin ? IDLE : RUN);
  always_comb busy = state == RUN;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      len_q <= '0;
      op_q <= '0;
      t_q <= 1'b0;
      sh <= '0;
      done <= 1'b0;
      out <= '0;
      out_hi <= '0;
      zero <= 1'b0;
      carry <= 1'b0;
    end else begin
      done <= (accept && len == CW'(1)) || fin;
      if (accept) begin
        op_q <= op;
        t_q <= t;
        len_q <= len;
        sh <= shifted;
        cnt <= len == CW'(1) ? '0 : CW'(1);
        if (len == CW'(1)) begin
          out <= res;
          out_hi <= '0;
          zero <= res == '0;
          carry <= res_c;
        end
      end else if (fin) begin
        cnt <= '0;
        out <= op_q == kLRS ? shifted : prod[WIDTH-1:0];
        out_hi <= op_q == kLRS ? '0 : prod[2*WIDTH-1:WIDTH];
        zero <= op_q == kLRS ? shifted == '0 : prod == '0;
        carry <= op_q == kLRS ? sbit : carry;
      end else if (busy) begin
        cnt <= cnt + CW'(1);
        sh <= shifted;
      end
    end
  end
  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .reset_n(reset_n),
    .load(accept && op == kMUL),
    .step(busy && op_q == kMUL),
    .a(inputa),
    .b(inputb),
    .prod(prod)
  );
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed and random checks of multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;
  import multicycle_alu_pkg::*;
  logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, t = 1'b0;
  logic [3:0] op = '0;
  logic [7:0] a = '0, b = '0;
  logic [4:0] imm = '0;
  logic busy, done, zero, carry;
  logic [7:0] out, out_hi;
  int errors = 0, checks = 0;
  logic [7:0] out_m = '0, hi_m = '0;
  logic carry_m = 1'b0;
  always #5 clk = ~clk;
  multicycle_alu #(.WIDTH(8), .IMMW(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .t(t),
    .inputa(a), .inputb(b), .imm(imm), .busy(busy), .done(done),
    .out(out), .out_hi(out_hi), .zero(zero), .carry(carry)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model(input logic [3:0] opv, input logic tv, input logic [7:0] av, input logic [7:0] bv,
                       input logic [4:0] iv, output int lat, output logic [7:0] lo, output logic [7:0] hi,
                       output logic c);
    int s, nn;
    lat = 1; lo = '0; hi = '0; c = carry_m;
    case (opv)
      kADD: begin s = int'(av) + int'(bv) + (tv ? int'(carry_m) : 0); lo = 8'(s); c = s > 255; end
      kXOR: lo = av ^ bv;
      kGST: lo = tv ? bv : av;
      kACC: lo = {3'b0, iv};
      kENQ: lo = ((av == bv) != tv) ? 8'd1 : 8'd0;
      kEQI: lo = ((bv == {3'b0, iv}) != tv) ? 8'd1 : 8'd0;
      kLRS: begin
        nn = int'(bv[3:0]);
        if (nn > 8) nn = 8;
        lat = nn == 0 ? 1 : nn;
        if (nn == 0) lo = av;
        else if (tv) begin lo = 8'(int'(av) >> nn); c = 1'((int'(av) >> (nn - 1)) & 1); end
        else begin lo = 8'(int'(av) << nn); c = 1'(((int'(av) << (nn - 1)) >> 7) & 1); end
      end
      kMUL: begin s = int'(av) * int'(bv); lo = 8'(s); hi = 8'(s >> 8); lat = 8; end
      default: ;
    endcase
  endtask
  task automatic run_op(input string tag, input logic [3:0] opv, input logic tv, input logic [7:0] av,
                        input logic [7:0] bv, input logic [4:0] iv, input int poke);
    int lat;
    logic [7:0] lo, hi;
    logic c;
    model(opv, tv, av, bv, iv, lat, lo, hi, c);
    op = opv; t = tv; a = av; b = bv; imm = iv; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      check({tag, "_hold"}, {15'd0, carry, out_hi, out}, {15'd0, carry_m, hi_m, out_m});
      if (k == poke) begin start = 1'b1; op = kADD; a = 8'hFF; b = 8'h01; t = 1'b0; end
      tick();
      start = 1'b0;
    end
    check({tag, "_done"}, {30'd0, done, busy}, 32'b10);
    check({tag, "_res"}, {15'd0, carry, out_hi, out}, {15'd0, c, hi, lo});
    check({tag, "_zero"}, 32'(zero), 32'({hi, lo} == 16'd0));
    out_m = lo; hi_m = hi; carry_m = c;
  endtask
  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("reset", {12'd0, busy, done, zero, carry, out_hi, out}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    run_op("add_ff_01", kADD, 1'b0, 8'hFF, 8'h01, 5'd0, 0);
    check("add_ff_01_vec", {22'd0, zero, carry, out}, {22'd0, 1'b1, 1'b1, 8'h00});
    run_op("adc_01_01", kADD, 1'b1, 8'h01, 8'h01, 5'd0, 0);
    check("adc_01_01_vec", {23'd0, carry, out}, {23'd0, 1'b0, 8'h03});
    run_op("lrs_81_3", kLRS, 1'b0, 8'h81, 8'h03, 5'd0, 0);
    check("lrs_81_3_vec", {23'd0, carry, out}, {23'd0, 1'b0, 8'h08});
    run_op("lrs_ff_9", kLRS, 1'b1, 8'hFF, 8'h09, 5'd0, 0);
    check("lrs_ff_9_vec", {22'd0, zero, carry, out}, {22'd0, 1'b1, 1'b1, 8'h00});
    run_op("mul_ff_ff", kMUL, 1'b0, 8'hFF, 8'hFF, 5'd0, 3);
    check("mul_ff_ff_vec", {16'd0, out_hi, out}, 32'h0000FE01);
    tick();
    check("mul_single_done", 32'(done), 32'd0);
    op = kMUL; a = 8'hA5; b = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("abort_reset", {12'd0, busy, done, zero, carry, out_hi, out}, 32'd0);
    out_m = '0; hi_m = '0; carry_m = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("abort_nodone", {30'd0, busy, done}, 32'd0);
    end
    run_op("xor_0f_ff", kXOR, 1'b0, 8'h0F, 8'hFF, 5'd0, 0);
    check("xor_0f_ff_vec", 32'(out), 32'hF0);
    run_op("b2b_lrs", kLRS, 1'b1, 8'hB6, 8'h02, 5'd0, 0);
    run_op("b2b_eqi", kEQI, 1'b0, 8'h00, 8'h05, 5'd5, 0);
    check("b2b_eqi_vec", 32'(out), 32'h01);
    run_op("undef", 4'hF, 1'b1, 8'h12, 8'h34, 5'd3, 0);
    check("undef_vec", {23'd0, zero, out}, {23'd0, 1'b1, 8'h00});
    run_op("lrs_n0", kLRS, 1'b0, 8'h5A, 8'h10, 5'd0, 0);
    for (int i = 0; i < 150; i++) begin
      run_op("rnd", 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 8'($urandom),
             $urandom_range(0, 1) == 1 ? 8'($urandom_range(0, 15)) : 8'($urandom), 5'($urandom), 0);
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check("rnd_idle", {14'd0, busy, done, carry, out_hi, out}, {16'd0, carry_m, hi_m, out_m});
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
